// File: rtl/dsram_ctrl_pkg.sv
// Shared types for the data-SRAM controller: FSM states, access-size codes
// and the alignment rule used at request acceptance.
package dsram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 behaves as a word access everywhere downstream.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dsram_ctrl_align.sv
// Byte-lane steering: store strobe/replication and load shift/extension.
module dsram_align
    import dsram_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_in >> {addr_lo, 3'b000};
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = shifted;
        case (size)
            SZ_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb     = 4'b0011 << addr_lo;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/dsram_ctrl.sv
// Single-outstanding load/store controller between EX/ME and an SRAM-like bus.
// Handshakes: EX request fires when ex_req_valid & ex_req_ready; SRAM request
// fires on data_sram_req & data_sram_addr_ok; ME result fires on me_data_valid & me_allow_in.
module dsram_ctrl
    import dsram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_req_valid,
    input  logic              ex_req_we,
    input  logic [1:0]        ex_req_size,
    input  logic              ex_req_signed,
    input  logic [ADDR_W-1:0] ex_req_addr,
    input  logic [31:0]       ex_req_wdata,
    output logic              ex_req_ready,
    input  logic              flush,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              me_data_valid,
    output logic [31:0]       me_rdata,
    output logic              me_ale,
    input  logic              me_allow_in,
    output logic [1:0]        dbg_state
);

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ale_q, ale_d;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    dsram_align u_align (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .sign_ext  (signed_q),
        .wdata_in  (wdata_q),
        .rdata_in  (data_sram_rdata),
        .wstrb     (al_wstrb),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cancel_d     = cancel_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ale_d        = ale_q;
        ex_req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cancel_d     = 1'b0;
                ex_req_ready = ex_req_valid & ~flush;
                if (ex_req_ready) begin
                    we_d     = ex_req_we;
                    size_d   = norm_size(ex_req_size);
                    signed_d = ex_req_signed;
                    addr_d   = ex_req_addr;
                    wdata_d  = ex_req_wdata;
                    rdata_d  = 32'd0;
                    ale_d    = is_misaligned(norm_size(ex_req_size), ex_req_addr[1:0]);
                    state_d  = ale_d ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                // The bus request is never withdrawn; a flush only marks the result as dead.
                if (flush) cancel_d = 1'b1;
                if (data_sram_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) cancel_d = 1'b1;
                if (data_sram_data_ok) begin
                    if (cancel_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = we_q ? 32'd0 : al_rdata;
                        state_d = ST_RESP;
                    end
                end
            end
            default: begin
                if (me_allow_in | flush) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            ale_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ale_q    <= ale_d;
        end
    end

    // Bus and ME outputs are forced to zero outside the states that own them.
    always_comb begin
        data_sram_req   = (state_q == ST_REQ);
        data_sram_wr    = data_sram_req & we_q;
        data_sram_size  = data_sram_req ? size_q : 2'd0;
        data_sram_wstrb = data_sram_req ? al_wstrb : 4'd0;
        data_sram_addr  = data_sram_req ? addr_q : '0;
        data_sram_wdata = data_sram_req ? al_wdata : 32'd0;
        me_data_valid   = (state_q == ST_RESP);
        me_rdata        = me_data_valid ? rdata_q : 32'd0;
        me_ale          = me_data_valid & ale_q;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_dsram_ctrl.sv
// Directed bench for dsram_ctrl: the SRAM side is driven cycle by cycle from the sequence.
module tb_dsram_ctrl;

    logic        clk;
    logic        reset;
    logic        ex_req_valid;
    logic        ex_req_we;
    logic [1:0]  ex_req_size;
    logic        ex_req_signed;
    logic [31:0] ex_req_addr;
    logic [31:0] ex_req_wdata;
    logic        ex_req_ready;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        me_data_valid;
    logic [31:0] me_rdata;
    logic        me_ale;
    logic        me_allow_in;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    dsram_ctrl #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_req_valid      (ex_req_valid),
        .ex_req_we         (ex_req_we),
        .ex_req_size       (ex_req_size),
        .ex_req_signed     (ex_req_signed),
        .ex_req_addr       (ex_req_addr),
        .ex_req_wdata      (ex_req_wdata),
        .ex_req_ready      (ex_req_ready),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .me_data_valid     (me_data_valid),
        .me_rdata          (me_rdata),
        .me_ale            (me_ale),
        .me_allow_in       (me_allow_in),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present a request in the current IDLE cycle; returns one cycle after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ex_req_valid  = 1'b1;
        ex_req_we     = we;
        ex_req_size   = size;
        ex_req_signed = sgn;
        ex_req_addr   = addr;
        ex_req_wdata  = wdata;
        settle();
        chk("ex_req_ready", ex_req_ready, 1);
        step();
        ex_req_valid = 1'b0;
        settle();
    endtask

    // Serve the SRAM request: addr_ok after aw cycles, data_ok after dw cycles in WAIT.
    task automatic sram(input int aw, input int dw, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic exp_wr, input logic [1:0] exp_size);
        chk("sram_req", data_sram_req, 1);
        chk("sram_addr", data_sram_addr, exp_addr);
        chk("sram_wr", data_sram_wr, exp_wr);
        chk("sram_size", data_sram_size, exp_size);
        for (int i = 0; i < aw; i++) begin
            step();
            chk("sram_req_held", data_sram_req, 1);
            chk("sram_addr_held", data_sram_addr, exp_addr);
        end
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        settle();
        chk("sram_req_drop", data_sram_req, 0);
        for (int i = 0; i < dw; i++) begin
            step();
            chk("no_valid_in_wait", me_data_valid, 0);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        step();
        data_sram_data_ok = 1'b0;
        settle();
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp_rdata, input logic exp_ale);
        chk({tag, "_valid"}, me_data_valid, 1);
        chk({tag, "_rdata"}, me_rdata, exp_rdata);
        chk({tag, "_ale"}, me_ale, exp_ale);
        me_allow_in = 1'b1;
        step();
        me_allow_in = 1'b0;
        settle();
        chk({tag, "_valid_drop"}, me_data_valid, 0);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        ex_req_valid      = 1'b0;
        ex_req_we         = 1'b0;
        ex_req_size       = 2'd0;
        ex_req_signed     = 1'b0;
        ex_req_addr       = 32'd0;
        ex_req_wdata      = 32'd0;
        flush             = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        me_allow_in       = 1'b0;
        step();
        step();
        chk("rst_state", dbg_state, 0);
        chk("rst_sram_req", data_sram_req, 0);
        chk("rst_wstrb", data_sram_wstrb, 0);
        chk("rst_valid", me_data_valid, 0);
        chk("rst_rdata", me_rdata, 0);
        reset = 1'b0;
        step();

        // Word load, addr_ok after 1 cycle, data_ok after 2.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0);
        sram(1, 2, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 2'd2);
        expect_resp("ld_word", 32'hDEAD_BEEF, 1'b0);

        // Byte loads from lane 3, signed then unsigned.
        issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0);
        sram(0, 0, 32'h80FF_FF12, 32'h0000_1003, 1'b0, 2'd0);
        expect_resp("ld_byte_s", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0);
        sram(0, 1, 32'h80FF_FF12, 32'h0000_1003, 1'b0, 2'd0);
        expect_resp("ld_byte_u", 32'h0000_0080, 1'b0);

        // Half store to upper half.
        issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        chk("st_half_wstrb", data_sram_wstrb, 32'b1100);
        chk("st_half_wdata", data_sram_wdata, 32'hABCD_ABCD);
        sram(0, 0, 32'h5555_5555, 32'h0000_2002, 1'b1, 2'd1);
        expect_resp("st_half", 32'd0, 1'b0);

        // Byte store to lane 1.
        issue(1'b1, 2'd0, 1'b0, 32'h0000_7001, 32'h0000_00A5);
        chk("st_byte_wstrb", data_sram_wstrb, 32'b0010);
        chk("st_byte_wdata", data_sram_wdata, 32'hA5A5_A5A5);
        sram(0, 0, 32'd0, 32'h0000_7001, 1'b1, 2'd0);
        expect_resp("st_byte", 32'd0, 1'b0);

        // Misaligned word load: straight to RESP, never on the bus.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0);
        chk("mis_sram_req", data_sram_req, 0);
        expect_resp("mis_word", 32'd0, 1'b1);

        // Flush during WAIT: data_ok absorbed, then immediate re-accept.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        settle();
        chk("flush_wait_ready", ex_req_ready, 0);
        step();
        flush = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk("flush_wait_no_valid", me_data_valid, 0);
        chk("flush_wait_idle", dbg_state, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'd0);
        sram(0, 0, 32'hBEEF_1234, 32'h0000_4002, 1'b0, 2'd1);
        expect_resp("ld_half_u", 32'h0000_BEEF, 1'b0);

        // Flush together with addr_ok in REQ: request stays up, response dropped.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_4100, 32'd0);
        data_sram_addr_ok = 1'b1;
        flush = 1'b1;
        settle();
        chk("flush_req_held", data_sram_req, 1);
        step();
        data_sram_addr_ok = 1'b0;
        flush = 1'b0;
        settle();
        chk("flush_req_wait", dbg_state, 2);
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk("flush_req_no_valid", me_data_valid, 0);
        chk("flush_req_idle", dbg_state, 0);

        // RESP held for 3 cycles while ME stalls; EX is kept waiting.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'd0);
        sram(0, 0, 32'h0123_4567, 32'h0000_5004, 1'b0, 2'd2);
        ex_req_valid = 1'b1;
        ex_req_addr  = 32'h0000_5008;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", me_data_valid, 1);
            chk("hold_rdata", me_rdata, 32'h0123_4567);
            chk("hold_ready", ex_req_ready, 0);
            step();
        end
        ex_req_valid = 1'b0;
        settle();
        expect_resp("hold", 32'h0123_4567, 1'b0);

        // Signed half load with sign bit set.
        issue(1'b0, 2'd1, 1'b1, 32'h0000_6002, 32'd0);
        sram(0, 0, 32'h8001_0000, 32'h0000_6002, 1'b0, 2'd1);
        expect_resp("ld_half_s", 32'hFFFF_8001, 1'b0);

        // Reset in the middle of an access abandons it.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
        reset = 1'b1;
        settle();
        chk("midrst_req", data_sram_req, 0);
        chk("midrst_state", dbg_state, 0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_no_valid", me_data_valid, 0);

        // Size code 3 behaves as a word.
        issue(1'b0, 2'd3, 1'b0, 32'h0000_9000, 32'd0);
        sram(0, 0, 32'hCAFE_F00D, 32'h0000_9000, 1'b0, 2'd2);
        expect_resp("ld_size3", 32'hCAFE_F00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
